// File: rtl/perf_event_counters.sv
// -----------------------------------------------------------------------------
// perf_event_counters
//
// Hardware performance-monitor bank for the pipelined CPU. It counts NUM_CH
// single-bit event strobes plus a free-running cycle counter. Arithmetic either
// saturates or wraps. Counting freezes on a processor halt or when the
// cycle-limit watchdog fires. Every count can be read through a registered
// read port.
//
// Parameters
//   NUM_CH     number of event channels (1..15)
//   CNT_W      width of every counter, cycle counter included (8..32)
//   SAT_MODE   1: saturate at all-ones, 0: wrap to zero
//   CYC_LIMIT  cycle count that triggers the watchdog. A limit that does not
//              fit in CNT_W bits can never be reached, so the watchdog is
//              then disabled.
//   SEL_W      read-select width, $clog2(NUM_CH+1)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         start counting (sampled in IDLE)
//   event_in   per-channel event strobes, one count per high cycle in RUN
//   halt       processor halt strobe, freezes counting (RUN only)
//   clr        synchronous clear of counters and flags, returns to IDLE
//   rd_sel     0..NUM_CH-1 selects a channel, NUM_CH selects the cycle counter
//   rd_data    registered read data (pre-update value of the same edge)
//   ovf        sticky overflow flags, bit NUM_CH is the cycle counter
//   running    high in RUN
//   frozen     high in FROZEN
//   timeout    sticky, the watchdog caused the freeze
// -----------------------------------------------------------------------------
module perf_event_counters #(
    parameter int NUM_CH    = 6,
    parameter int CNT_W     = 32,
    parameter int SAT_MODE  = 1,
    parameter int CYC_LIMIT = 100000,
    parameter int SEL_W     = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NUM_CH-1:0] event_in,
    input  logic              halt,
    input  logic              clr,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH:0]   ovf,
    output logic              running,
    output logic              frozen,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    // Watchdog only exists when the limit is representable in a counter.
    localparam longint CNT_SPAN = longint'(1) << CNT_W;
    localparam bit WD_EN = (CYC_LIMIT >= 1) && (longint'(CYC_LIMIT) < CNT_SPAN);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYC_LIMIT - 1);

    state_t state;

    // Index NUM_CH holds the cycle counter, the rest are the event channels.
    logic [CNT_W-1:0] cnt     [NUM_CH+1];
    logic [CNT_W-1:0] cntNext [NUM_CH+1];
    logic [NUM_CH:0]  incReq;
    logic [NUM_CH:0]  ovfHit;
    logic [CNT_W-1:0] rdMux;
    logic             wdHit;

    // The cycle counter always ticks in RUN; channels tick on their strobe.
    assign incReq = (state == RUN) ? {1'b1, event_in} : '0;

    generate
        for (genvar gi = 0; gi <= NUM_CH; gi++) begin : g_cnt
            logic atMax;
            assign atMax       = &cnt[gi];
            assign ovfHit[gi]  = incReq[gi] & atMax;
            assign cntNext[gi] = !incReq[gi]    ? cnt[gi] :
                                 !atMax         ? cnt[gi] + CNT_W'(1) :
                                 (SAT_MODE != 0) ? cnt[gi] : '0;
        end
    endgenerate

    // Fires on the RUN cycle whose tick brings the cycle counter to the limit,
    // so the limit value itself is kept in the counter.
    assign wdHit = WD_EN && (state == RUN) && (cnt[NUM_CH] == LIMIT_M1);

    // Selects the current (pre-update) count; out-of-range selects read 0.
    always_comb begin
        rdMux = '0;
        for (int i = 0; i <= NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rdMux = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_data <= '0;
            ovf     <= '0;
            running <= 1'b0;
            frozen  <= 1'b0;
            timeout <= 1'b0;
            for (int i = 0; i <= NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rd_data <= rdMux;
            if (clr) begin
                // clr outranks halt, the watchdog and en.
                state   <= IDLE;
                ovf     <= '0;
                running <= 1'b0;
                frozen  <= 1'b0;
                timeout <= 1'b0;
                for (int i = 0; i <= NUM_CH; i++) begin
                    cnt[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (en) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        // The halt / watchdog cycle is still counted.
                        for (int i = 0; i <= NUM_CH; i++) begin
                            cnt[i] <= cntNext[i];
                        end
                        ovf <= ovf | ovfHit;
                        if (halt || wdHit) begin
                            state   <= FROZEN;
                            running <= 1'b0;
                            frozen  <= 1'b1;
                        end
                        if (wdHit) begin
                            timeout <= 1'b1;
                        end
                    end
                    FROZEN: begin
                        state <= FROZEN;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        frozen  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_perf_event_counters.sv
// Testbench for perf_event_counters: directed stimulus with a scoreboard queue.
// Stimulus pushes expected responses tagged with the cycle on which the DUT
// presents them; a negedge monitor pops and compares.
module tb_perf_event_counters;

    localparam int NCH = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: 32-bit, saturating, watchdog at 20 cycles
    logic           en = 0, halt = 0, clr = 0;
    logic [NCH-1:0] ev = '0;
    logic [2:0]     rdSel = '0;
    logic [31:0]    rdData;
    logic [NCH:0]   ovfA;
    logic           running, frozen, timeout;

    // 8-bit saturate / wrap instances sharing one stimulus
    logic           enS = 0, haltS = 0, clrS = 0;
    logic [NCH-1:0] evS = '0;
    logic [2:0]     rdSelS = '0;
    logic [7:0]     rdS, rdW;
    logic [NCH:0]   ovfS, ovfW;
    logic           runS, frzS, toS, runW, frzW, toW;

    perf_event_counters #(.NUM_CH(NCH), .CNT_W(32), .SAT_MODE(1), .CYC_LIMIT(20)) dutA (
        .clk(clk), .rst_n(rst_n), .en(en), .event_in(ev), .halt(halt), .clr(clr),
        .rd_sel(rdSel), .rd_data(rdData), .ovf(ovfA), .running(running),
        .frozen(frozen), .timeout(timeout));

    perf_event_counters #(.NUM_CH(NCH), .CNT_W(8), .SAT_MODE(1), .CYC_LIMIT(100000)) dutS (
        .clk(clk), .rst_n(rst_n), .en(enS), .event_in(evS), .halt(haltS), .clr(clrS),
        .rd_sel(rdSelS), .rd_data(rdS), .ovf(ovfS), .running(runS),
        .frozen(frzS), .timeout(toS));

    perf_event_counters #(.NUM_CH(NCH), .CNT_W(8), .SAT_MODE(0), .CYC_LIMIT(100000)) dutW (
        .clk(clk), .rst_n(rst_n), .en(enS), .event_in(evS), .halt(haltS), .clr(clrS),
        .rd_sel(rdSelS), .rd_data(rdW), .ovf(ovfW), .running(runW),
        .frozen(frzW), .timeout(toW));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 rdData, 1 status {ovfA,running,frozen,timeout}, 2 rdS, 3 rdW,
    //       4 ovfS[NCH-1:0], 5 ovfW[NCH-1:0]
    typedef struct {
        int          due;
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic pushExp(input int off, input int kind, input logic [63:0] v, input string nm);
        exp_t e;
        e.due  = cyc + off;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    function automatic logic [63:0] stA(input logic [NCH:0] o, input logic r, input logic f, input logic t);
        return 64'({o, r, f, t});
    endfunction

    function automatic logic [63:0] actualOf(input int kind);
        case (kind)
            0:       return 64'(rdData);
            1:       return 64'({ovfA, running, frozen, timeout});
            2:       return 64'(rdS);
            3:       return 64'(rdW);
            4:       return 64'(ovfS[NCH-1:0]);
            default: return 64'(ovfW[NCH-1:0]);
        endcase
    endfunction

    // Monitor: compare every entry that falls due on this cycle.
    exp_t mon;
    logic [63:0] act;
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon = sbq.pop_front();
            act = actualOf(mon.kind);
            checks++;
            if (mon.due != cyc || act != mon.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h (due %0d)",
                         mon.name, cyc, act, mon.exp, mon.due);
            end else begin
                $display("ok   %s cyc=%0d: 0x%0h", mon.name, cyc, act);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int basicExp [8] = '{11, 0, 11, 0, 0, 0, 11, 0};

    initial begin
        // ---------------- reset ----------------
        repeat (3) tick();
        rst_n = 1'b1;
        pushExp(0, 1, stA('0, 0, 0, 0), "reset_status");
        pushExp(0, 0, 0, "reset_rd_data");
        pushExp(0, 4, 0, "reset_ovfS");
        tick();

        // ---------------- basic count ----------------
        en = 1; ev = 6'b000101;
        tick(); en = 0;
        repeat (4) tick();
        pushExp(0, 1, stA('0, 1, 0, 0), "basic_running");
        repeat (6) tick();
        halt = 1;
        tick(); halt = 0; ev = '0;
        pushExp(0, 1, stA('0, 0, 1, 0), "basic_frozen");
        for (int i = 0; i < 8; i++) begin
            rdSel = 3'(i);
            pushExp(1, 0, 64'(basicExp[i]), $sformatf("basic_rd%0d", i));
            tick();
        end

        // ---------------- watchdog ----------------
        clr = 1;
        tick(); clr = 0; en = 1; ev = 6'b100000;
        pushExp(0, 1, stA('0, 0, 0, 0), "wd_after_clr");
        tick(); en = 0;
        repeat (19) tick();
        pushExp(0, 1, stA('0, 1, 0, 0), "wd_still_running");
        tick();
        pushExp(0, 1, stA('0, 0, 1, 1), "wd_fired");
        repeat (3) tick();
        ev = '0;
        rdSel = 3'd5; pushExp(1, 0, 20, "wd_ch5"); tick();
        rdSel = 3'd6; pushExp(1, 0, 20, "wd_cycles"); tick();
        rdSel = 3'd0; pushExp(1, 0, 0, "wd_ch0"); tick();

        // ---------------- clear priority ----------------
        clr = 1;
        tick(); clr = 0; en = 1; ev = 6'h3F;
        tick(); en = 0;
        tick(); tick();
        rdSel = 3'd6; pushExp(1, 0, 2, "read_lag_cycles");
        tick();
        clr = 1; halt = 1;
        tick(); clr = 0; halt = 0; ev = '0;
        pushExp(0, 1, stA('0, 0, 0, 0), "clr_over_halt");
        for (int i = 0; i < 7; i++) begin
            rdSel = 3'(i);
            pushExp(1, 0, 0, $sformatf("clr_rd%0d", i));
            tick();
        end
        pushExp(0, 1, stA('0, 0, 0, 0), "clr_stays_idle");

        // ---------------- saturate / wrap ----------------
        enS = 1; evS = 6'b000001;
        tick(); enS = 0;
        repeat (255) tick();
        pushExp(0, 4, 0, "sat_ovf_before");
        pushExp(0, 5, 0, "wrap_ovf_before");
        tick();
        pushExp(0, 4, 1, "sat_ovf_256th");
        pushExp(0, 5, 1, "wrap_ovf_256th");
        repeat (44) tick();
        evS = '0; haltS = 1;
        tick(); haltS = 0;
        rdSelS = 3'd0;
        pushExp(1, 2, 8'hFF, "sat_ch0");
        pushExp(1, 3, 44, "wrap_ch0");
        tick();
        rdSelS = 3'd6;
        pushExp(1, 2, 8'hFF, "sat_cycles");
        pushExp(1, 3, 45, "wrap_cycles");
        tick();
        pushExp(0, 4, 1, "sat_ovf_final");

        // ---------------- async reset ----------------
        rdSel = 3'd0;
        en = 1; ev = 6'b000001;
        tick(); en = 0;
        tick(); tick(); tick();
        rdSel = 3'd6; pushExp(1, 0, 3, "pre_reset_cycles");
        tick(); tick();
        #1 rst_n = 1'b0;
        pushExp(0, 1, stA('0, 0, 0, 0), "async_status");
        pushExp(0, 0, 0, "async_rd_data");
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        pushExp(0, 1, stA('0, 0, 0, 0), "post_reset_idle");
        rdSel = 3'd0; pushExp(1, 0, 0, "post_reset_ch0"); tick();
        rdSel = 3'd6; pushExp(1, 0, 0, "post_reset_cycles"); tick();
        en = 1;
        tick(); en = 0;
        tick(); tick();
        rdSel = 3'd0; pushExp(1, 0, 2, "resume_ch0"); tick();
        ev = '0;
        repeat (3) tick();

        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/perf_event_counters.md
# perf_event_counters

Parametrised hardware performance-monitor bank for the pipelined CPU with I/D caches. Counts NUM_CH single-bit event strobes (retired instructions, I-cache requests/hits, D-cache requests/hits, …) plus a free-running cycle counter, with selectable saturate/wrap arithmetic. Freezes on halt or a cycle-limit watchdog, and exposes every count through a registered read port, so the statistics are available in synthesised hardware rather than only in simulation.

## Interface
Parameters:
- NUM_CH, 6: number of event channels (1..15).
- CNT_W, 32: width of each counter, including the cycle counter (8..32).
- SAT_MODE, 1: 1 = counters saturate at all-ones; 0 = counters wrap to 0.
- CYC_LIMIT, 100000: cycle count at which the watchdog fires (must be < 2^CNT_W).
- SEL_W, derived as $clog2(NUM_CH+1): read-select width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  start counting; level, sampled in IDLE.
- event_in  in  NUM_CH  per-channel event strobes, one count per high cycle.
- halt  in  1  processor halt strobe; freezes counting.
- clr  in  1  synchronous clear of all counters and flags.
- rd_sel  in  SEL_W  read index: 0..NUM_CH-1 selects a channel; NUM_CH selects the cycle counter.
- rd_data  out  CNT_W  registered read data.
- ovf  out  NUM_CH+1  sticky overflow flags; bit NUM_CH belongs to the cycle counter.
- running  out  1  high in RUN.
- frozen  out  1  high in FROZEN.
- timeout  out  1  sticky; the watchdog caused the freeze.

## Operation
- FSM states and transitions:
  - IDLE: counters hold. Goes to RUN when en=1.
  - RUN: counting. Goes to FROZEN on halt=1 or on the watchdog.
  - FROZEN: counters hold. Leaves only on clr.
- clr in any state: zero all counters, ovf and timeout; next state IDLE. clr has priority over halt, the watchdog and en.
- In RUN, every cycle:
  - The cycle counter increments by 1.
  - Each channel i increments by 1 when event_in[i]=1.
- Events and the cycle tick in the halt cycle are still counted. The halt cycle is included in all totals. Counting stops from the next cycle.
- Watchdog: the cycle counter reaching CYC_LIMIT in RUN goes to FROZEN and sets timeout. The count that reaches the limit is kept. If halt arrives in the same cycle, timeout is still set.
- Overflow: an increment attempted while a counter is all-ones sets that counter's ovf bit, which stays set until clr or reset.
  - SAT_MODE=1: the counter stays at all-ones.
  - SAT_MODE=0: the counter becomes 0.
- Read port:
  - rd_data <= counter[rd_sel] on every edge, in every state.
  - rd_sel > NUM_CH returns 0.
  - The value read is the pre-update count of the same edge, so it lags a concurrent increment by one cycle.
- event_in is ignored in IDLE and FROZEN.
- halt is ignored outside RUN.

## Timing
- Reset values (asynchronous, held while rst_n=0):
  - state IDLE; all counters 0; rd_data 0; ovf 0; running 0; frozen 0; timeout 0.
- en high at edge k: RUN after edge k, running=1. The first counted cycle is the one following edge k.
- Event at edge k in RUN: the counter shows it after edge k. rd_data shows it after edge k+1 (1-cycle read latency).
- halt at edge k: counts include cycle k. frozen=1 after edge k.
- clr at edge k: all zero after edge k. rd_data returns 0 after edge k+1.
- Reset asserted mid-operation: immediate return to the reset values with no partial update. Counting resumes only after rst_n deasserts and en is seen in IDLE.
- No combinational path from inputs to outputs.

## Test plan
- Basic count: NUM_CH=6, CNT_W=32. After reset, en=1. Drive event_in=6'b000101 for 10 cycles, then halt.
  - Channels 0 and 2 read 11 (10 cycles plus the halt cycle); the others read 0.
  - Cycle counter reads 11; frozen=1; timeout=0.
- Saturation: CNT_W=8, SAT_MODE=1. Drive 300 events on ch0.
  - ch0 reads 0xFF; ovf[0]=1 from the 256th event onward; the other ovf bits are 0.
  - With SAT_MODE=0, the same stimulus reads 300 mod 256 = 44 and ovf[0]=1.
- Watchdog: CYC_LIMIT=20, no halt.
  - After 20 RUN cycles: frozen=1, timeout=1, cycle counter reads 20.
  - Further events are not counted.
- Clear priority: assert clr and halt together in RUN.
  - All counters read 0; state IDLE (running=0, frozen=0); ovf=0; timeout=0.
- Read port: rd_sel=NUM_CH returns the cycle count; rd_sel=NUM_CH+1 returns 0.
  - Change rd_sel each cycle and check rd_data follows with exactly 1 cycle latency.
- Async reset: drop rst_n mid-cycle during RUN with counts at 5.
  - All outputs are 0 immediately, before the next clock edge.
  - After release, counters stay 0 until en=1.
